// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl
//   Returns a credit as coins by repeatedly picking the largest coin that
//   fits the remaining credit and whose hopper tube is not empty, then
//   offering that coin to the hopper until it is accepted.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   refund_req    start a refund (sampled only while idle)
//   credit[7:0]   credit to return, captured with refund_req
//   coin_empty[4:0] bit i set: tube for denomination code i is empty
//   dispense_ack  hopper accepted the offered coin
//   dispense_valid coin offer to hopper
//   dispense_sel[2:0] denomination code of the offered coin
//   busy          controller not idle
//   done          one-cycle completion pulse
//   short         credit could not be fully returned
//   remaining[7:0] credit not yet returned
//   coin_count[4:0] coins dispensed in current/last refund (saturates at 31)
//
// Denomination codes: 0=5, 1=10, 2=20, 3=50, 4=100. Codes 5-7 are never driven.
//
// Hopper handshake: dispense_valid is high for the whole ISSUE state and
// dispense_sel is held constant while it is high. A coin is transferred on
// every rising edge where dispense_valid and dispense_ack are both high;
// dispense_valid then drops for at least one cycle before the next offer.
// dispense_ack is ignored whenever dispense_valid is low.
module change_dispense_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refund_req,
  input  logic [7:0] credit,
  input  logic [4:0] coin_empty,
  input  logic       dispense_ack,
  output logic       dispense_valid,
  output logic [2:0] dispense_sel,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [7:0] remaining,
  output logic [4:0] coin_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0] state;
  logic       pick_found;
  logic [2:0] pick_code;

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = 8'd5;
      3'd1:    coin_value = 8'd10;
      3'd2:    coin_value = 8'd20;
      3'd3:    coin_value = 8'd50;
      3'd4:    coin_value = 8'd100;
      default: coin_value = 8'd0;
    endcase
  endfunction

  // Ascending scan: the last eligible code wins, which is the largest coin
  // that still fits. Only used in SELECT, so coin_empty changes during ISSUE
  // cannot disturb the coin already on offer.
  always_comb begin
    pick_found = 1'b0;
    pick_code  = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (!coin_empty[i] && (coin_value(3'(i)) <= remaining)) begin
        pick_found = 1'b1;
        pick_code  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      dispense_sel <= 3'd0;
      short        <= 1'b0;
      remaining    <= 8'd0;
      coin_count   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (refund_req) begin
            remaining  <= credit;
            coin_count <= 5'd0;
            short      <= 1'b0;
            state      <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remaining == 8'd0) begin
            state <= ST_DONE;
          end else if (pick_found) begin
            dispense_sel <= pick_code;
            state        <= ST_ISSUE;
          end else begin
            short <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          if (dispense_ack) begin
            // Cannot underflow: SELECT only offers coins no larger than remaining.
            remaining <= remaining - coin_value(dispense_sel);
            if (coin_count != 5'd31) begin
              coin_count <= coin_count + 5'd1;
            end
            state <= ST_SELECT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dispense_valid = (state == ST_ISSUE);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb_change_dispense_ctrl
//   Table-driven refunds plus hand-written corner sequences. The expected
//   coin sequence of each refund is queued before it starts and popped as the
//   hopper sees each offer.
module tb_change_dispense_ctrl;

  logic       clk;
  logic       rst_n;
  logic       refund_req;
  logic [7:0] credit;
  logic [4:0] coin_empty;
  logic       dispense_ack;
  logic       dispense_valid;
  logic [2:0] dispense_sel;
  logic       busy;
  logic       done;
  logic       short_flag;
  logic [7:0] remaining;
  logic [4:0] coin_count;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0]  credit;
    logic [4:0]  empty;
    int          delay;
    int          n_sel;
    logic [23:0] seq;      // first coin in bits [23:21], next in [20:18], ...
    logic [7:0]  exp_rem;
    logic        exp_short;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs[10];

  change_dispense_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .refund_req     (refund_req),
    .credit         (credit),
    .coin_empty     (coin_empty),
    .dispense_ack   (dispense_ack),
    .dispense_valid (dispense_valid),
    .dispense_sel   (dispense_sel),
    .busy           (busy),
    .done           (done),
    .short          (short_flag),
    .remaining      (remaining),
    .coin_count     (coin_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic [7:0] c, input logic [4:0] e,
                         input int dly, input int n, input logic [23:0] s,
                         input logic [7:0] rem, input logic sh, input logic [4:0] cnt);
    vecs[idx].credit    = c;
    vecs[idx].empty     = e;
    vecs[idx].delay     = dly;
    vecs[idx].n_sel     = n;
    vecs[idx].seq       = s;
    vecs[idx].exp_rem   = rem;
    vecs[idx].exp_short = sh;
    vecs[idx].exp_cnt   = cnt;
  endtask

  // Independent greedy reference for the random refunds.
  function automatic int coin_val(input int code);
    case (code)
      0: return 5;
      1: return 10;
      2: return 20;
      3: return 50;
      default: return 100;
    endcase
  endfunction

  // Runs one refund. Expected coin codes must already be in exp_q.
  // Inputs change #1 after a rising edge; outputs are sampled at the same point.
  task automatic run_refund(input logic [7:0] c, input logic [4:0] e, input int dly,
                            input bit pulse, input logic [7:0] exp_rem,
                            input logic exp_short, input logic [4:0] exp_cnt,
                            input int exp_lat);
    int  cycles;
    bit  got_done;
    logic [2:0] held;
    @(posedge clk); #1;
    refund_req = 1'b1;
    credit     = c;
    coin_empty = e;
    @(posedge clk); #1;
    refund_req = 1'b0;
    check("busy_after_req", busy, 1);
    cycles   = 0;
    got_done = 0;
    while (!got_done && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (done) begin
        got_done = 1;
      end else if (dispense_valid) begin
        held = dispense_sel;
        if (exp_q.size() == 0) begin
          check("unexpected_offer", 1, 0);
        end else begin
          check("sel", dispense_sel, exp_q.pop_front());
        end
        for (int k = 0; k < dly; k++) begin
          if (pulse) begin
            refund_req = 1'b1;
            credit     = 8'd99;
          end
          coin_empty = 5'b11111;   // must not disturb the coin on offer
          @(posedge clk); #1;
          cycles++;
          check("valid_held", dispense_valid, 1);
          check("sel_held", dispense_sel, held);
        end
        refund_req   = 1'b0;
        credit       = c;
        coin_empty   = e;
        dispense_ack = 1'b1;
        @(posedge clk); #1;
        cycles++;
        dispense_ack = 1'b0;
        check("valid_drop_after_ack", dispense_valid, 0);
      end
    end
    check("done_seen", got_done, 1);
    if (exp_lat >= 0) check("done_latency", cycles + 1, exp_lat);
    check("remaining", remaining, exp_rem);
    check("short", short_flag, exp_short);
    check("coin_count", coin_count, exp_cnt);
    check("missing_offers", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("remaining_hold", remaining, exp_rem);
    check("count_hold", coin_count, exp_cnt);
  endtask

  initial begin
    refund_req   = 1'b0;
    credit       = 8'd0;
    coin_empty   = 5'd0;
    dispense_ack = 1'b0;
    rst_n        = 1'b0;

    set_vec(0, 8'd185, 5'b00000, 0, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 9'd0}, 8'd0, 1'b0, 5'd5);
    set_vec(1, 8'd100, 5'b10000, 0, 2, {3'd3, 3'd3, 18'd0},                 8'd0, 1'b0, 5'd2);
    set_vec(2, 8'd7,   5'b00000, 0, 1, {3'd0, 21'd0},                       8'd2, 1'b1, 5'd1);
    set_vec(3, 8'd0,   5'b00000, 0, 0, 24'd0,                               8'd0, 1'b0, 5'd0);
    set_vec(4, 8'd30,  5'b00000, 3, 2, {3'd2, 3'd1, 18'd0},                 8'd0, 1'b0, 5'd2);
    set_vec(5, 8'd255, 5'b00000, 1, 4, {3'd4, 3'd4, 3'd3, 3'd0, 12'd0},     8'd0, 1'b0, 5'd4);
    set_vec(6, 8'd35,  5'b00001, 0, 2, {3'd2, 3'd1, 18'd0},                 8'd5, 1'b1, 5'd2);
    set_vec(7, 8'd3,   5'b00000, 0, 0, 24'd0,                               8'd3, 1'b1, 5'd0);
    set_vec(8, 8'd255, 5'b11111, 0, 0, 24'd0,                               8'd255, 1'b1, 5'd0);
    set_vec(9, 8'd60,  5'b01000, 2, 3, {3'd2, 3'd2, 3'd2, 15'd0},           8'd0, 1'b0, 5'd3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", dispense_valid, 0);
    check("rst_sel", dispense_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short_flag, 0);
    check("rst_remaining", remaining, 0);
    check("rst_count", coin_count, 0);
    rst_n = 1'b1;

    // Table-driven refunds; delayed-ack rows also pulse refund_req while busy
    for (int v = 0; v < 10; v++) begin
      for (int s = 0; s < vecs[v].n_sel; s++) begin
        exp_q.push_back(vecs[v].seq[23 - 3*s -: 3]);
      end
      run_refund(vecs[v].credit, vecs[v].empty, vecs[v].delay, vecs[v].delay > 0,
                 vecs[v].exp_rem, vecs[v].exp_short, vecs[v].exp_cnt,
                 (vecs[v].credit == 8'd0) ? 2 : -1);
    end

    // Ack while idle must not count a coin
    dispense_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dispense_ack = 1'b0;
    check("idle_ack_count", coin_count, 3);
    check("idle_ack_busy", busy, 0);
    check("idle_ack_remaining", remaining, 0);

    // Coin counter saturation: 51 five-unit coins
    for (int s = 0; s < 51; s++) exp_q.push_back(3'd0);
    run_refund(8'd255, 5'b11110, 0, 1'b0, 8'd0, 1'b0, 5'd31, -1);

    // Reset in the middle of an offer, with ack high on the reset edge
    @(posedge clk); #1;
    refund_req = 1'b1;
    credit     = 8'd50;
    coin_empty = 5'd0;
    @(posedge clk); #1;
    refund_req = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", dispense_valid, 1);
    check("pre_rst_sel", dispense_sel, 3);
    rst_n        = 1'b0;
    dispense_ack = 1'b1;
    @(posedge clk); #1;
    rst_n        = 1'b1;
    dispense_ack = 1'b0;
    check("midrst_valid", dispense_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_remaining", remaining, 0);
    check("midrst_count", coin_count, 0);
    check("midrst_sel", dispense_sel, 0);
    check("midrst_done", done, 0);
    exp_q.push_back(3'd2);
    run_refund(8'd20, 5'd0, 0, 1'b0, 8'd0, 1'b0, 5'd1, -1);

    // Random refunds against a greedy reference
    for (int r = 0; r < 6; r++) begin
      int c, e, d, rem, cnt;
      bit sh, found;
      c   = $urandom_range(0, 255);
      e   = $urandom_range(0, 31);
      d   = $urandom_range(0, 2);
      rem = c;
      cnt = 0;
      sh  = 0;
      while (rem > 0 && !sh) begin
        found = 0;
        for (int i = 4; i >= 0 && !found; i--) begin
          if (!e[i] && coin_val(i) <= rem) begin
            found = 1;
            exp_q.push_back(3'(i));
            rem -= coin_val(i);
            if (cnt < 31) cnt++;
          end
        end
        if (!found) sh = 1;
      end
      run_refund(8'(c), 5'(e), d, 1'b0, 8'(rem), sh, 5'(cnt), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, synchronous, active-low.
REQ-002 SHALL have these ports after clk and rst_n:
- refund_req input 1: start refund, sampled only in IDLE.
- credit input 8: unsigned credit to return, sampled with refund_req.
- coin_empty input 5: bit i high means hopper tube for denomination code i is empty.
- dispense_ack input 1: hopper accepted the offered coin.
- dispense_valid output 1: coin offer to hopper.
- dispense_sel output 3: denomination code of the offered coin.
- busy output 1: controller not IDLE.
- done output 1: one-cycle completion pulse.
- short output 1: credit could not be fully returned.
- remaining output 8: unreturned credit.
- coin_count output 5: coins dispensed in the current or last refund.
REQ-003 SHALL use denomination codes 0=5, 1=10, 2=20, 3=50, 4=100; codes 5-7 SHALL never be driven.

Function
REQ-004 SHALL implement states IDLE, SELECT, ISSUE, DONE in one state register; busy SHALL equal (state != IDLE).
REQ-005 IDLE: refund_req=1 at an edge SHALL load remaining<=credit, coin_count<=0, short<=0, and move to SELECT.
REQ-006 SELECT, remaining==0: SHALL move to DONE with short=0.
REQ-007 SELECT, remaining>0: SHALL choose the highest code i with value(i) <= remaining and coin_empty[i]==0, register dispense_sel<=i, and move to ISSUE.
REQ-008 SELECT, remaining>0 and no eligible code: SHALL set short<=1 and move to DONE, leaving remaining unchanged.
REQ-009 ISSUE: dispense_valid SHALL be 1 and dispense_sel SHALL stay stable until dispense_ack=1 at an edge.
REQ-010 ISSUE, on ack: SHALL set remaining<=remaining-value(sel), coin_count<=coin_count+1 (saturating at 31), and return to SELECT. Valid SHALL drop for at least the SELECT cycle; each ack consumes exactly one coin.
REQ-011 dispense_ack outside ISSUE SHALL be ignored.
REQ-012 coin_empty SHALL be sampled only in SELECT; changes during ISSUE SHALL NOT affect the offered coin.
REQ-013 DONE: done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-014 remaining, short and coin_count SHALL hold after DONE until the next accepted refund_req.
REQ-015 refund_req while busy SHALL be ignored, with no queuing.
REQ-016 remaining SHALL never underflow; the subtraction is guarded by REQ-007.
REQ-017 Latency: for credit=0, done SHALL be asserted 2 cycles after the refund_req edge; each coin SHALL cost 2 cycles (SELECT + ISSUE) plus ack wait cycles.

Reset
REQ-018 rst_n=0 at an edge SHALL force state=IDLE, dispense_valid=0, dispense_sel=0, busy=0, done=0, short=0, remaining=0, coin_count=0, including mid-refund; no partial ack SHALL be counted.
REQ-019 After rst_n returns high, the first refund_req SHALL be accepted normally.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- credit=185, coin_empty=0, ack same cycle as valid -> sel sequence 4,3,2,1,0; done; remaining=0; short=0; coin_count=5.
- credit=100, coin_empty=5'b10000 -> sel 3,3; remaining=0; coin_count=2.
- credit=7 -> sel 0 once; done; short=1; remaining=2; coin_count=1.
- credit=0 -> done 2 cycles after refund_req; dispense_valid never high; coin_count=0.
- credit=30, ack delayed 3 cycles, refund_req pulsed while busy -> valid and sel=2 held 4 cycles, then sel=1; second request ignored; remaining=0.
- rst_n low during ISSUE of credit=50 -> next cycle valid=0, busy=0, remaining=0; a new refund_req with credit=20 then dispenses sel=2.
